// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Merges the in-order pipeline writeback stage and the multiply/divide unit
//   (MDU) onto the single register_file write port. The pipeline has fixed
//   priority and is never stalled. MDU results are accepted through a
//   valid/ready handshake into a 2-entry buffer. A per-register busy
//   scoreboard tracks outstanding MDU destinations for decode hazard checks.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   pipe_valid/addr/data            pipeline writeback request
//   mdu_issue, mdu_issue_addr       MDU issue (reserves destination)
//   mdu_valid/addr/data, mdu_ready  MDU result handshake
//   rd_addr_1, rd_addr_2, rd_addr_w decode-stage register addresses
//   hazard                          decode must stall
//   busy                            scoreboard bit vector
//   rf_write_en/addr/data           registered register_file write port
module reg_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              mdu_issue,
  input  logic [ADDR_W-1:0] mdu_issue_addr,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  input  logic [ADDR_W-1:0] rd_addr_w,
  output logic              hazard,
  output logic [NREGS-1:0]  busy,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  // Result buffer state
  logic [ADDR_W-1:0] fifo_addr_r [2];
  logic [DATA_W-1:0] fifo_data_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;

  // Scoreboard and write port registers
  logic [NREGS-1:0]  busy_r;
  logic              rf_write_en_r;
  logic [ADDR_W-1:0] rf_write_addr_r;
  logic [DATA_W-1:0] rf_write_data_r;

  // Arbitration results
  logic              mdu_ready_s;
  logic              xfer_s;
  logic              pipe_win_s;
  logic              push_s;
  logic              pop_s;
  logic              win_en_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;
  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic [NREGS-1:0]  busy_next_s;
  logic [1:0]        count_next_s;

  // Ready depends only on the buffer occupancy register
  assign mdu_ready_s = (count_r != 2'd2);
  assign xfer_s      = mdu_valid & mdu_ready_s;
  // A pipeline write to register 0 is dropped so it never blocks the buffer
  assign pipe_win_s  = pipe_valid & (pipe_addr != ZERO_ADDR);

  // Priority arbitration: pipeline, then buffer head, then MDU bypass
  always_comb begin
    push_s     = 1'b0;
    pop_s      = 1'b0;
    win_en_s   = 1'b0;
    win_addr_s = ZERO_ADDR;
    win_data_s = ZERO_DATA;
    clr_en_s   = 1'b0;
    clr_addr_s = ZERO_ADDR;
    if (pipe_win_s) begin
      win_en_s   = 1'b1;
      win_addr_s = pipe_addr;
      win_data_s = pipe_data;
      push_s     = xfer_s;
    end else if (count_r != 2'd0) begin
      pop_s      = 1'b1;
      push_s     = xfer_s;
      win_addr_s = fifo_addr_r[rd_ptr_r];
      win_data_s = fifo_data_r[rd_ptr_r];
      win_en_s   = (fifo_addr_r[rd_ptr_r] != ZERO_ADDR);
      clr_en_s   = (fifo_addr_r[rd_ptr_r] != ZERO_ADDR);
      clr_addr_s = fifo_addr_r[rd_ptr_r];
    end else if (xfer_s) begin
      win_addr_s = mdu_addr;
      win_data_s = mdu_data;
      win_en_s   = (mdu_addr != ZERO_ADDR);
      clr_en_s   = (mdu_addr != ZERO_ADDR);
      clr_addr_s = mdu_addr;
    end else begin
      win_en_s   = 1'b0;
    end
  end

  // Scoreboard next state: clear on MDU write, then a new reservation wins
  always_comb begin
    busy_next_s = busy_r;
    if (clr_en_s) begin
      busy_next_s[clr_addr_s] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (mdu_issue && (mdu_issue_addr != ZERO_ADDR)) begin
      busy_next_s[mdu_issue_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Buffer occupancy next state; push with count 2 cannot occur (ready low)
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Buffer storage and pointers; flushed on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_addr_r[0] <= ZERO_ADDR;
      fifo_addr_r[1] <= ZERO_ADDR;
      fifo_data_r[0] <= ZERO_DATA;
      fifo_data_r[1] <= ZERO_DATA;
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= mdu_addr;
        fifo_data_r[wr_ptr_r] <= mdu_data;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Registered write port; address/data hold when no write is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_en_r   <= 1'b0;
      rf_write_addr_r <= ZERO_ADDR;
      rf_write_data_r <= ZERO_DATA;
    end else begin
      rf_write_en_r <= win_en_s;
      if (win_en_s) begin
        rf_write_addr_r <= win_addr_s;
        rf_write_data_r <= win_data_s;
      end
    end
  end

  assign mdu_ready     = mdu_ready_s;
  assign busy          = busy_r;
  assign hazard        = busy_r[rd_addr_1] | busy_r[rd_addr_2] | busy_r[rd_addr_w];
  assign rf_write_en   = rf_write_en_r;
  assign rf_write_addr = rf_write_addr_r;
  assign rf_write_data = rf_write_data_r;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter.
module tb_reg_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic [4:0]  rd_addr_w;
  logic        hazard;
  logic [31:0] busy;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  int tests;
  int failed;

  reg_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_addr_w(rd_addr_w),
    .hazard(hazard), .busy(busy),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    mdu_issue = 1'b0; mdu_issue_addr = 5'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    idle_inputs();
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; rd_addr_w = 5'd0;
    #12;
    check("rst_en",    64'(rf_write_en), 64'd0);
    check("rst_addr",  64'(rf_write_addr), 64'd0);
    check("rst_data",  64'(rf_write_data), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ready", 64'(mdu_ready), 64'd1);
    check("rst_haz",   64'(hazard), 64'd0);
    rst_n = 1'b1;

    // Pipeline write, 1-cycle latency
    pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1234;
    tick();
    idle_inputs();
    check("p_en",   64'(rf_write_en), 64'd1);
    check("p_addr", 64'(rf_write_addr), 64'd5);
    check("p_data", 64'(rf_write_data), 64'h1234);
    tick();
    check("p_idle_en", 64'(rf_write_en), 64'd0);

    // Issue to 9, hazard, bypass completion
    mdu_issue = 1'b1; mdu_issue_addr = 5'd9;
    tick();
    idle_inputs();
    rd_addr_1 = 5'd9;
    #1;
    check("b9_busy", 64'(busy), 64'h200);
    check("b9_haz",  64'(hazard), 64'd1);
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hCAFE;
    #1;
    check("b9_ready", 64'(mdu_ready), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("byp_en",   64'(rf_write_en), 64'd1);
    check("byp_addr", 64'(rf_write_addr), 64'd9);
    check("byp_data", 64'(rf_write_data), 64'hCAFE);
    check("byp_busy", 64'(busy), 64'd0);
    check("byp_haz",  64'(hazard), 64'd0);
    rd_addr_1 = 5'd0;

    // Reserve 10 and 11, then pipeline burst while MDU offers results
    mdu_issue = 1'b1; mdu_issue_addr = 5'd10;
    tick();
    mdu_issue_addr = 5'd11;
    tick();
    idle_inputs();
    check("b1011_busy", 64'(busy), 64'h0C00);
    pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h11;
    mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 32'hA0;
    #1;
    check("bur_rdy0", 64'(mdu_ready), 64'd1);
    tick();
    check("bur_w1", 64'(rf_write_addr), 64'd1);
    pipe_addr = 5'd2; pipe_data = 32'h22;
    mdu_addr = 5'd11; mdu_data = 32'hB0;
    #1;
    check("bur_rdy1", 64'(mdu_ready), 64'd1);
    tick();
    check("bur_w2", 64'(rf_write_addr), 64'd2);
    pipe_addr = 5'd3; pipe_data = 32'h33;
    mdu_valid = 1'b0;
    #1;
    check("bur_rdy2", 64'(mdu_ready), 64'd0);
    tick();
    check("bur_w3", 64'(rf_write_addr), 64'd3);
    pipe_addr = 5'd4; pipe_data = 32'h44;
    tick();
    check("bur_w4", 64'(rf_write_addr), 64'd4);
    check("bur_w4_data", 64'(rf_write_data), 64'h44);
    idle_inputs();
    tick();
    check("fifo10_en",   64'(rf_write_en), 64'd1);
    check("fifo10_addr", 64'(rf_write_addr), 64'd10);
    check("fifo10_data", 64'(rf_write_data), 64'hA0);
    check("fifo10_busy", 64'(busy), 64'h0800);
    tick();
    check("fifo11_en",   64'(rf_write_en), 64'd1);
    check("fifo11_addr", 64'(rf_write_addr), 64'd11);
    check("fifo11_data", 64'(rf_write_data), 64'hB0);
    check("fifo11_busy", 64'(busy), 64'd0);
    check("fifo11_rdy",  64'(mdu_ready), 64'd1);
    tick();
    check("drain_en", 64'(rf_write_en), 64'd0);

    // Zero register: bypass to 0, buffered 0 entry, ignored pipe addr 0
    pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hFF;
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hEE;
    tick();
    check("z_byp_en", 64'(rf_write_en), 64'd0);
    pipe_addr = 5'd3; pipe_data = 32'h3333;
    tick();
    check("z_p3_en",   64'(rf_write_en), 64'd1);
    check("z_p3_addr", 64'(rf_write_addr), 64'd3);
    pipe_addr = 5'd0;
    mdu_valid = 1'b0;
    tick();
    check("z_pop_en", 64'(rf_write_en), 64'd0);
    pipe_valid = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd6; mdu_data = 32'h66;
    tick();
    idle_inputs();
    check("z_empty_en",   64'(rf_write_en), 64'd1);
    check("z_empty_addr", 64'(rf_write_addr), 64'd6);
    check("z_busy",       64'(busy), 64'd0);

    // Re-reservation wins over completion in the same cycle
    mdu_issue = 1'b1; mdu_issue_addr = 5'd7;
    tick();
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h77;
    tick();
    idle_inputs();
    check("r7_en",   64'(rf_write_en), 64'd1);
    check("r7_busy", 64'(busy), 64'h80);
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h78;
    tick();
    idle_inputs();
    check("r7_clr", 64'(busy), 64'd0);

    // Mid-operation reset with a full buffer and busy bits
    mdu_issue = 1'b1; mdu_issue_addr = 5'd20;
    tick();
    mdu_issue_addr = 5'd21;
    tick();
    mdu_issue = 1'b0;
    pipe_valid = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h1;
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h20;
    tick();
    pipe_addr = 5'd2; mdu_addr = 5'd21; mdu_data = 32'h21;
    tick();
    idle_inputs();
    rd_addr_2 = 5'd20;
    #1;
    check("pre_rst_rdy",  64'(mdu_ready), 64'd0);
    check("pre_rst_busy", 64'(busy), 64'h300000);
    check("pre_rst_haz",  64'(hazard), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_en",    64'(rf_write_en), 64'd0);
    check("mrst_addr",  64'(rf_write_addr), 64'd0);
    check("mrst_data",  64'(rf_write_data), 64'd0);
    check("mrst_busy",  64'(busy), 64'd0);
    check("mrst_ready", 64'(mdu_ready), 64'd1);
    check("mrst_haz",   64'(hazard), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_en", 64'(rf_write_en), 64'd0);
    end
    rd_addr_2 = 5'd0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Decode must never issue to a register that is still reserved; the
  // deliberate re-reservation step completes that register in the same cycle.
  always @(posedge clk) begin
    if (rst_n && mdu_issue && (mdu_issue_addr != 5'd0) && busy[mdu_issue_addr]) begin
      assert (mdu_valid && mdu_ready && (mdu_addr == mdu_issue_addr))
        else $error("FAIL issue_to_busy observed=%0d expected=not busy", mdu_issue_addr);
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
